mips_alu_hilo: RTL and testbench
================================

Name: mips_alu_hilo

Overview:
HI/LO register stage directly downstream of the ALU.
- Commits ALU mul and move-to results into architectural HI/LO.
- Feeds HI/LO back to the ALU reg_hi/reg_lo inputs.
- Replaces the ALU's combinational divide with an iterative radix-2 restoring divider; issue stalls only on HI/LO hazards.

Parameters:
- DATA_W, 32, operand/register width.
- CNT_W, Util_Math_log2(DATA_W)+1, width of the iteration counter.

Ports:
- clock  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  instruction present at the ALU stage this cycle.
- func  input  `Mips_Alu_Func_T  ALU function code.
- data1  input  DATA_W  dividend (rs).
- data2  input  DATA_W  divisor (rt).
- alu_lo  input  DATA_W  ALU res_lo.
- alu_hi  input  DATA_W  ALU res_hi.
- flush  input  1  pipeline flush; cancels an in-flight divide.
- stall  output  1  combinational; the HI/LO-class instruction at in_valid is not accepted.
- busy  output  1  divide in progress.
- div_done  output  1  one-cycle pulse when the divide result is written.
- reg_lo  output  DATA_W  architectural LO, to ALU reg_lo.
- reg_hi  output  DATA_W  architectural HI, to ALU reg_hi.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - reg_lo=0, reg_hi=0, state=IDLE, busy=0, div_done=0, counter=0.
  - stall=0 while in reset.
- HI/LO-class funcs: Muls, Mulu, Divs, Divu, Mtlo, Mthi, Mflo, Mfhi.
- stall = in_valid & busy & func is HI/LO-class.
  - Non-HI/LO funcs never stall.
  - A stalled op has no effect.
- States: IDLE, RUN, FIX.
- IDLE, accepted op (in_valid & ~stall & ~flush):
  - Muls/Mulu: reg_lo<=alu_lo, reg_hi<=alu_hi at the next edge.
  - Mtlo: reg_lo<=alu_lo.
  - Mthi: reg_hi<=alu_hi.
  - Mflo/Mfhi: no state change; the ALU reads reg_lo/reg_hi the same cycle.
- IDLE, Divs/Divu accepted:
  - Latch operands: magnitudes for Divs, raw for Divu.
  - Latch sign flags: qneg = sign(d1)^sign(d2), rneg = sign(d1), both Divs only.
  - Load partial remainder=0, counter=DATA_W; go to RUN; busy=1 from the next cycle.
  - The divide instruction itself does not stall.
- Divide by zero (data2==0):
  - No RUN; the next edge writes reg_lo=all ones, reg_hi=data1.
  - div_done pulses for that cycle; busy stays 0.
- RUN, each cycle:
  - Shift {rem, quo} left by 1.
  - Trial-subtract the divisor from rem; if there is no borrow, rem=diff and quo[0]=1.
  - Decrement counter; at counter==1 go to FIX.
- FIX:
  - reg_lo = qneg ? -quo : quo.
  - reg_hi = rneg ? -rem : rem.
  - div_done=1; go to IDLE; busy=0 from the next cycle.
- Latency: Divs/Divu accepted in cycle T gives a result visible on reg_lo/reg_hi at T+DATA_W+2. busy is high T+1..T+DATA_W+1.
- Arithmetic rules:
  - MIN/-1 (Divs) yields reg_lo=MIN, reg_hi=0, using modular arithmetic with no trap.
  - All arithmetic is DATA_W modular.
- flush:
  - In RUN or FIX: go to IDLE, busy=0, no HI/LO write, no div_done.
  - flush and in_valid in the same cycle: flush wins; the op is discarded.
- Reset mid-divide: immediate IDLE, registers cleared.

Optional Feature:
- Macro: MIPS_ALU_HILO_EARLY_OUT_EN.
- Defined: in IDLE, accepted Divs/Divu with nonzero |divisor| > |dividend| (unsigned compare of latched magnitudes):
  - Skip RUN; go straight to FIX with quo=0, rem=|dividend|.
  - Result at T+2; busy high for cycle T+1 only.
- Undefined: every nonzero divide takes the full DATA_W+2 cycles.

Decomposition:
- Shared Mips_Alu_Func package gains `Mips_Alu_Func_IsHiLo(f)` and `Mips_Alu_Func_IsDiv(f)` predicates.
- State encoding is local to this module.
- One natural sub-module: mips_alu_div_step, a combinational single restoring iteration (rem_in, quo_in, divisor to rem_out, quo_out).

Test Plan:
- Reset, then Mulu with alu_hi=0x1, alu_lo=0x2 -> reg_hi=0x1, reg_lo=0x2 the next cycle; stall=0 throughout.
- Divu 100/7 accepted at T -> busy high T+1..T+33; reg_lo=14, reg_hi=2 at T+34; div_done pulses once.
- Divs -7/2 -> reg_lo=0xFFFFFFFD, reg_hi=0xFFFFFFFF.
- Divs 0x80000000/0xFFFFFFFF -> reg_lo=0x80000000, reg_hi=0.
- Divu x/0 with x=0x1234 -> reg_lo=0xFFFFFFFF, reg_hi=0x1234 one cycle later; busy never high.
- During busy:
  - Mflo -> stall=1 until the cycle after FIX, then the correct quotient is read.
  - Add is not stalled.
  - flush at cycle T+10 -> busy=0, HI/LO unchanged, no div_done.

Source files
------------

// File: rtl/mips_alu_hilo_pkg.sv
// Shared ALU function codes and HI/LO classification predicates for the
// MIPS ALU and its HI/LO register stage.
package mips_alu_hilo_pkg;

  typedef enum logic [4:0] {
    FUNC_ADD,
    FUNC_ADDU,
    FUNC_SUB,
    FUNC_SUBU,
    FUNC_AND,
    FUNC_OR,
    FUNC_XOR,
    FUNC_NOR,
    FUNC_SLT,
    FUNC_SLTU,
    FUNC_SLL,
    FUNC_SRL,
    FUNC_SRA,
    FUNC_MULS,
    FUNC_MULU,
    FUNC_DIVS,
    FUNC_DIVU,
    FUNC_MTLO,
    FUNC_MTHI,
    FUNC_MFLO,
    FUNC_MFHI
  } mips_alu_func_t;

  // Any function that reads or writes HI/LO must wait out an in-flight divide.
  function automatic logic mips_alu_func_is_hilo(input mips_alu_func_t f);
    return f inside {FUNC_MULS, FUNC_MULU, FUNC_DIVS, FUNC_DIVU,
                     FUNC_MTLO, FUNC_MTHI, FUNC_MFLO, FUNC_MFHI};
  endfunction

  function automatic logic mips_alu_func_is_div(input mips_alu_func_t f);
    return f inside {FUNC_DIVS, FUNC_DIVU};
  endfunction

endpackage

// File: rtl/mips_alu_div_step.sv
// One combinational restoring-division iteration on the {rem, quo} pair.
module mips_alu_div_step #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rem_in,
  input  logic [DATA_W-1:0] quo_in,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] rem_out,
  output logic [DATA_W-1:0] quo_out
);

  // The shifted remainder can reach 2*divisor-1, so the trial uses one extra bit;
  // its MSB is the borrow.
  logic [DATA_W:0] rem_sh;
  logic [DATA_W:0] diff;

  always_comb begin
    rem_sh = {rem_in, quo_in[DATA_W-1]};
    diff   = rem_sh - {1'b0, divisor};
    if (diff[DATA_W]) begin
      rem_out = rem_sh[DATA_W-1:0];
      quo_out = {quo_in[DATA_W-2:0], 1'b0};
    end else begin
      rem_out = diff[DATA_W-1:0];
      quo_out = {quo_in[DATA_W-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/mips_alu_hilo.sv
// HI/LO register stage behind the ALU with an iterative radix-2 divider.
// Optional build macro MIPS_ALU_HILO_EARLY_OUT_EN: skip iterations when |divisor| > |dividend|.
module mips_alu_hilo
  import mips_alu_hilo_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = $clog2(DATA_W) + 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  input  mips_alu_func_t    func,
  input  logic [DATA_W-1:0] data1,
  input  logic [DATA_W-1:0] data2,
  input  logic [DATA_W-1:0] alu_lo,
  input  logic [DATA_W-1:0] alu_hi,
  input  logic              flush,
  output logic              stall,
  output logic              busy,
  output logic              div_done,
  output logic [DATA_W-1:0] reg_lo,
  output logic [DATA_W-1:0] reg_hi
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FIX} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rem_q, rem_d, quo_q, quo_d, dvsr_q, dvsr_d;
  logic [DATA_W-1:0] lo_q, lo_d, hi_q, hi_d;
  logic              qneg_q, qneg_d, rneg_q, rneg_d, done_q, done_d;

  logic              accept, d1_neg, d2_neg;
  logic [DATA_W-1:0] mag1, mag2, step_rem, step_quo;

  assign busy     = (state_q != ST_IDLE);
  assign stall    = in_valid & busy & mips_alu_func_is_hilo(func);
  assign accept   = in_valid & ~stall & ~flush & (state_q == ST_IDLE);
  assign div_done = done_q;
  assign reg_lo   = lo_q;
  assign reg_hi   = hi_q;

  // Signed divide works on magnitudes; MIN maps onto itself, which is the
  // correct unsigned magnitude 2^(DATA_W-1).
  assign d1_neg = (func == FUNC_DIVS) & data1[DATA_W-1];
  assign d2_neg = (func == FUNC_DIVS) & data2[DATA_W-1];
  assign mag1   = d1_neg ? -data1 : data1;
  assign mag2   = d2_neg ? -data2 : data2;

  mips_alu_div_step #(.DATA_W(DATA_W)) u_div_step (
    .rem_in  (rem_q),
    .quo_in  (quo_q),
    .divisor (dvsr_q),
    .rem_out (step_rem),
    .quo_out (step_quo)
  );

  always_comb begin
    // NOTE: every variable gets a hold/default value first so no path through
    // the case statements leaves it unassigned, which would infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvsr_d  = dvsr_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    done_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (func)
            FUNC_MULS, FUNC_MULU: begin
              lo_d = alu_lo;
              hi_d = alu_hi;
            end
            FUNC_MTLO: lo_d = alu_lo;
            FUNC_MTHI: hi_d = alu_hi;
            FUNC_DIVS, FUNC_DIVU: begin
              if (data2 == '0) begin
                lo_d   = '1;
                hi_d   = data1;
                done_d = 1'b1;
              end else begin
                dvsr_d  = mag2;
                quo_d   = mag1;
                rem_d   = '0;
                qneg_d  = d1_neg ^ d2_neg;
                rneg_d  = d1_neg;
                cnt_d   = CNT_W'(DATA_W);
                state_d = ST_RUN;
`ifdef MIPS_ALU_HILO_EARLY_OUT_EN
                if (mag2 > mag1) begin
                  quo_d   = '0;
                  rem_d   = mag1;
                  state_d = ST_FIX;
                end
`endif
              end
            end
            default: ;
          endcase
        end
      end

      ST_RUN: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          rem_d = step_rem;
          quo_d = step_quo;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) state_d = ST_FIX;
        end
      end

      ST_FIX: begin
        state_d = ST_IDLE;
        if (!flush) begin
          lo_d   = qneg_q ? -quo_q : quo_q;
          hi_d   = rneg_q ? -rem_q : rem_q;
          done_d = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvsr_q  <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      lo_q    <= '0;
      hi_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvsr_q  <= dvsr_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_mips_alu_hilo.sv
// Self-checking bench for mips_alu_hilo: divide results go through a scoreboard
// queue that is drained whenever div_done pulses.
module tb_mips_alu_hilo;
  import mips_alu_hilo_pkg::*;

  logic           clock;
  logic           reset_n;
  logic           in_valid;
  mips_alu_func_t func;
  logic [31:0]    data1, data2, alu_lo, alu_hi;
  logic           flush;
  logic           stall, busy, div_done;
  logic [31:0]    reg_lo, reg_hi;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fails  = 0;
  int   n_done   = 0;

  mips_alu_hilo dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .func     (func),
    .data1    (data1),
    .data2    (data2),
    .alu_lo   (alu_lo),
    .alu_hi   (alu_hi),
    .flush    (flush),
    .stall    (stall),
    .busy     (busy),
    .div_done (div_done),
    .reg_lo   (reg_lo),
    .reg_hi   (reg_hi)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Scoreboard consumer: every div_done pulse must match the oldest expectation.
  always @(negedge clock) begin : monitor
    exp_t e;
    if (reset_n && div_done) begin
      n_done++;
      if (exp_q.size() == 0) begin
        check("div_done_unexpected", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("div_lo", reg_lo, e.lo);
        check("div_hi", reg_hi, e.hi);
      end
    end
  end

  function automatic void model_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] lo, output logic [31:0] hi,
                                    output int lat);
    logic [31:0] ma, mb, q, r;
    bit an, bn;
    if (b == 32'd0) begin
      lo  = 32'hFFFF_FFFF;
      hi  = a;
      lat = 1;
      return;
    end
    an  = sgn & a[31];
    bn  = sgn & b[31];
    ma  = an ? -a : a;
    mb  = bn ? -b : b;
    q   = ma / mb;
    r   = ma % mb;
    lo  = (an ^ bn) ? -q : q;
    hi  = an ? -r : r;
    lat = 34;
`ifdef MIPS_ALU_HILO_EARLY_OUT_EN
    if (mb > ma) lat = 2;
`endif
  endfunction

  // Issue one divide, push its expected result, and measure latency and busy span.
  task automatic run_div(input string tag, input mips_alu_func_t f,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] lo, input logic [31:0] hi, input int lat);
    int   k;
    int   busy_cnt;
    exp_t e;
    e.lo = lo;
    e.hi = hi;
    exp_q.push_back(e);
    in_valid = 1'b1;
    func     = f;
    data1    = a;
    data2    = b;
    #1;
    check({tag, "_issue_stall"}, stall, 0);
    tick();
    in_valid = 1'b0;
    func     = FUNC_ADD;
    k        = 1;
    busy_cnt = 0;
    while (!div_done && k < 60) begin
      busy_cnt += int'(busy);
      tick();
      k++;
    end
    check({tag, "_latency"}, k, lat);
    check({tag, "_busy_cycles"}, busy_cnt, lat - 1);
    check({tag, "_busy_at_done"}, busy, 0);
    tick();
  endtask

  task automatic do_op(input mips_alu_func_t f, input logic [31:0] lo, input logic [31:0] hi);
    in_valid = 1'b1;
    func     = f;
    alu_lo   = lo;
    alu_hi   = hi;
    #1;
    check("op_stall", stall, 0);
    tick();
    in_valid = 1'b0;
    func     = FUNC_ADD;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [31:0] lo, hi, a, b;
    logic [31:0] pre_lo, pre_hi;
    int lat, k, done_before;
    bit sgn;

    reset_n  = 1'b0;
    in_valid = 1'b1;
    func     = FUNC_MFLO;
    data1    = '0;
    data2    = '0;
    alu_lo   = '0;
    alu_hi   = '0;
    flush    = 1'b0;
    #1;
    check("rst_stall", stall, 0);
    check("rst_busy", busy, 0);
    check("rst_done", div_done, 0);
    check("rst_lo", reg_lo, 0);
    check("rst_hi", reg_hi, 0);
    in_valid = 1'b0;
    func     = FUNC_ADD;
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    // Multiply and move-to commits
    do_op(FUNC_MULU, 32'h2, 32'h1);
    check("mulu_lo", reg_lo, 32'h2);
    check("mulu_hi", reg_hi, 32'h1);
    do_op(FUNC_MULS, 32'hFFFF_FFFE, 32'hFFFF_FFFF);
    check("muls_lo", reg_lo, 32'hFFFF_FFFE);
    check("muls_hi", reg_hi, 32'hFFFF_FFFF);
    do_op(FUNC_MTLO, 32'hAAAA_5555, 32'h1111_1111);
    check("mtlo_lo", reg_lo, 32'hAAAA_5555);
    check("mtlo_hi", reg_hi, 32'hFFFF_FFFF);
    do_op(FUNC_MTHI, 32'h2222_2222, 32'h0BAD_F00D);
    check("mthi_lo", reg_lo, 32'hAAAA_5555);
    check("mthi_hi", reg_hi, 32'h0BAD_F00D);
    do_op(FUNC_MFLO, 32'h3333_3333, 32'h4444_4444);
    check("mflo_lo", reg_lo, 32'hAAAA_5555);
    check("mflo_hi", reg_hi, 32'h0BAD_F00D);

    // Directed divides with hand-computed results
    run_div("divu_100_7", FUNC_DIVU, 32'd100, 32'd7, 32'd14, 32'd2, 34);
    run_div("divs_m7_2", FUNC_DIVS, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 34);
    run_div("divs_min_m1", FUNC_DIVS, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 34);
    run_div("divu_by_zero", FUNC_DIVU, 32'h1234, 32'h0, 32'hFFFF_FFFF, 32'h1234, 1);
    run_div("divs_by_zero", FUNC_DIVS, 32'hFFFF_FF00, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FF00, 1);
`ifdef MIPS_ALU_HILO_EARLY_OUT_EN
    run_div("divu_5_9", FUNC_DIVU, 32'd5, 32'd9, 32'd0, 32'd5, 2);
`else
    run_div("divu_5_9", FUNC_DIVU, 32'd5, 32'd9, 32'd0, 32'd5, 34);
`endif

    // Random divides against the reference model
    for (int i = 0; i < 6; i++) begin
      sgn = 1'($urandom_range(0, 1));
      a   = $urandom;
      b   = (i % 3 == 0) ? 32'($urandom_range(1, 20)) : $urandom;
      model_div(sgn, a, b, lo, hi, lat);
      run_div(sgn ? "rand_divs" : "rand_divu", sgn ? FUNC_DIVS : FUNC_DIVU, a, b, lo, hi, lat);
    end

    // Mflo during a divide stalls until the cycle after FIX; Add never stalls
    exp_q.push_back('{lo: 32'd100, hi: 32'd0});
    in_valid = 1'b1;
    func     = FUNC_DIVU;
    data1    = 32'd1000;
    data2    = 32'd10;
    #1;
    tick();
    func = FUNC_ADD;
    #1;
    check("add_no_stall", stall, 0);
    func = FUNC_MFLO;
    #1;
    k = 1;
    while (stall && k < 60) begin
      tick();
      k++;
      #1;
    end
    check("mflo_stall_release", k, 34);
    check("mflo_reads_quotient", reg_lo, 32'd100);
    in_valid = 1'b0;
    func     = FUNC_ADD;
    tick();

    // Flush mid-divide: no write-back, no div_done
    do_op(FUNC_MULU, 32'h11, 32'h22);
    pre_lo      = 32'h11;
    pre_hi      = 32'h22;
    done_before = n_done;
    in_valid    = 1'b1;
    func        = FUNC_DIVU;
    data1       = 32'hFFFF;
    data2       = 32'd3;
    #1;
    tick();
    in_valid = 1'b0;
    func     = FUNC_ADD;
    for (int i = 0; i < 9; i++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_busy", busy, 0);
    for (int i = 0; i < 40; i++) tick();
    check("flush_no_done", n_done, done_before);
    check("flush_lo", reg_lo, pre_lo);
    check("flush_hi", reg_hi, pre_hi);

    // Flush together with a valid op in IDLE discards the op
    in_valid = 1'b1;
    func     = FUNC_MULU;
    alu_lo   = 32'h99;
    alu_hi   = 32'h98;
    flush    = 1'b1;
    tick();
    in_valid = 1'b0;
    flush    = 1'b0;
    func     = FUNC_ADD;
    check("flush_op_lo", reg_lo, pre_lo);
    check("flush_op_hi", reg_hi, pre_hi);

    // Asynchronous reset in the middle of a divide
    in_valid = 1'b1;
    func     = FUNC_DIVU;
    data1    = 32'd50;
    data2    = 32'd3;
    #1;
    tick();
    in_valid = 1'b0;
    func     = FUNC_ADD;
    for (int i = 0; i < 4; i++) tick();
    check("pre_rst_busy", busy, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_lo", reg_lo, 0);
    check("mid_rst_hi", reg_hi, 0);
    check("mid_rst_done", div_done, 0);
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 40; i++) tick();
    check("post_rst_lo", reg_lo, 0);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
